neokeon_round_const_xor_pipe: RTL and testbench
===============================================

// Module: neokeon_round_const_xor_pipe
// PURPOSE
//  Sequential round-constant stage for the Neokeon128 datapath. Generates the Neokeon round-constant
//  sequence internally (forward for encrypt, backward for decrypt) and XORs it into one selectable word
//  of each state accepted. Replaces per-round constant wiring in the round loop. Sits between the round
//  controller and Theta, with valid/ready handshakes on both sides and a 1-deep output register.
// PARAMETERS
//  STATE_W   128     state width in bits; multiple of WORD_W
//  WORD_W    32      word width; constant is zero-extended to WORD_W
//  WORD_SEL  0       target word index counted from MSB (0 = bits [STATE_W-1 -: WORD_W])
//  NUM_XORS  17      constant applications per block (16 rounds + final)
//  RC_ENC    8'h80   first constant in encrypt mode
//  RC_DEC    8'hD4   first constant in decrypt mode
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous, active-high reset
//  start      in   1        begin new block; sampled only in IDLE
//  decrypt    in   1        mode, latched with start: 0 = forward LFSR, 1 = backward LFSR
//  in_valid   in   1        in_state valid
//  in_ready   out  1        stage accepts in_state this cycle
//  in_state   in   STATE_W  state from previous round step
//  out_valid  out  1        out_state valid
//  out_ready  in   1        downstream accepts out_state
//  out_state  out  STATE_W  in_state with constant XORed into word WORD_SEL
//  out_rc     out  8        constant applied to out_state
//  out_last   out  1        out_state is the NUM_XORS-th transfer of the block
//  busy       out  1        FSM in RUN
// BEHAVIOUR
//  - Reset values: state IDLE, rc=RC_ENC, cnt=0, out_valid=0, out_state=0, out_rc=0, out_last=0,
//    busy=0, in_ready=0. Reset mid-block aborts the block and discards a pending output.
//  - FSM IDLE: in_ready=0. start=1 -> RUN next cycle; rc<=decrypt?RC_DEC:RC_ENC; cnt<=0; mode latched.
//  - FSM RUN: in_ready = !out_valid || out_ready. start is ignored. Transfer = in_valid && in_ready.
//  - On transfer: out_state <= in_state ^ ({{WORD_W-8}{0},rc} << (STATE_W-WORD_W*(WORD_SEL+1)));
//    out_rc<=rc; out_last<=(cnt==NUM_XORS-1); out_valid<=1; cnt<=cnt+1; rc advances.
//    Latency is 1 cycle. Words other than WORD_SEL pass through bit-exact.
//  - rc forward: rc[7] ? (rc<<1)^8'h1B : rc<<1 (GF(2^8) xtime, poly 0x11B).
//  - rc backward: rc[0] ? (rc^8'h1B)>>1 | 8'h80 : rc>>1 (exact inverse of forward).
//  - Transfer with cnt==NUM_XORS-1: FSM -> IDLE next cycle, cnt cleared. The output register still
//    drains normally. start is accepted in the same cycle the FSM reaches IDLE.
//  - out_valid clears on out_ready && !transfer. Simultaneous drain and transfer: new data loads,
//    out_valid stays 1. out_valid=1 && !out_ready: out_* held stable, in_ready=0 (no overwrite).
//  - cnt width = $clog2(NUM_XORS+1). No transfer is accepted beyond NUM_XORS per block.
// TESTING
//  T1 enc, in_state=0, out_ready=1, 17 back-to-back transfers -> out_rc = 80,1B,36,6C,D8,AB,4D,9A,2F,
//     5E,BC,63,C6,97,35,6A,D4; out_state=={24'h0,rc,96'h0}; out_last only on 17th; busy drops after.
//  T2 dec, same stimulus -> out_rc is the T1 list reversed (D4 ... 80); return to IDLE after 17.
//  T3 in_state=128'hFFFF..FF, first enc transfer -> out_state=128'hFFFFFF7F_FFFFFFFF_FFFFFFFF_FFFFFFFF.
//  T4 backpressure: out_ready=0 for 5 cycles after 1st transfer -> in_ready=0, out_state/out_rc held;
//     release -> 2nd value 1B, no skipped or repeated constant.
//  T5 rst pulse asynchronously mid-block (after 6 transfers) -> out_valid=0 immediately; new start
//     restarts at 80.
//  T6 start pulsed during RUN -> ignored, sequence continues; WORD_SEL=3 build -> rc lands in bits [7:0].

Source files
------------

// File: rtl/neokeon_round_const_xor_pipe.sv
// ============================================================================
// neokeon_round_const_xor_pipe
// Neokeon round-constant generator (forward/backward LFSR) XORed into one
// word of each accepted state, with valid/ready handshakes and 1-deep output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module neokeon_round_const_xor_pipe #(
  parameter int         STATE_W  = 128,
  parameter int         WORD_W   = 32,
  parameter int         WORD_SEL = 0,
  parameter int         NUM_XORS = 17,
  parameter logic [7:0] RC_ENC   = 8'h80,
  parameter logic [7:0] RC_DEC   = 8'hD4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               decrypt,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic [7:0]         out_rc,
  output logic               out_last,
  output logic               busy
);

  localparam int                CNT_W    = $clog2(NUM_XORS + 1);
  localparam int                SHIFT    = STATE_W - WORD_W * (WORD_SEL + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NUM_XORS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [7:0]         rc;
  logic [7:0]         rc_next;
  logic [CNT_W-1:0]   cnt;
  logic               mode;
  logic               transfer;
  logic               last_xfer;
  logic [STATE_W-1:0] rc_mask;

  assign busy      = (state == RUN);
  assign in_ready  = (state == RUN) && (!out_valid || out_ready);
  assign transfer  = in_valid && in_ready;
  assign last_xfer = transfer && (cnt == CNT_LAST);

  // Constant is zero-extended to a full word, then placed at word WORD_SEL (MSB first).
  assign rc_mask = {{(STATE_W-8){1'b0}}, rc} << SHIFT;

  // Forward step is GF(2^8) xtime; backward step is its exact inverse.
  always_comb begin
    rc_next = rc;
    if (!mode) begin
      rc_next = rc[7] ? ((rc << 1) ^ 8'h1B) : (rc << 1);
    end else begin
      rc_next = rc[0] ? (((rc ^ 8'h1B) >> 1) | 8'h80) : (rc >> 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_xfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc        <= RC_ENC;
      cnt       <= '0;
      mode      <= 1'b0;
      out_valid <= 1'b0;
      out_state <= '0;
      out_rc    <= 8'h00;
      out_last  <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        rc   <= decrypt ? RC_DEC : RC_ENC;
        cnt  <= '0;
        mode <= decrypt;
      end

      if (transfer) begin
        out_state <= in_state ^ rc_mask;
        out_rc    <= rc;
        out_last  <= (cnt == CNT_LAST);
        cnt       <= last_xfer ? '0 : cnt + 1'b1;
        rc        <= rc_next;
      end

      // A simultaneous drain and load keeps the register full.
      if (transfer) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_neokeon_round_const_xor_pipe.sv
// ============================================================================
// tb_neokeon_round_const_xor_pipe
// Directed bench for the round-constant XOR stage (WORD_SEL=0 and WORD_SEL=3).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_neokeon_round_const_xor_pipe;

  logic         clk;
  logic         rst;
  logic         start;
  logic         decrypt;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_state;

  logic         in_ready,  out_valid,  out_last,  busy;
  logic [127:0] out_state;
  logic [7:0]   out_rc;
  logic         in_ready3, out_valid3, out_last3, busy3;
  logic [127:0] out_state3;
  logic [7:0]   out_rc3;

  int errors = 0;
  int checks = 0;

  logic [7:0] enc_rc [17] = '{8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A, 8'h2F,
                              8'h5E, 8'hBC, 8'h63, 8'hC6, 8'h97, 8'h35, 8'h6A, 8'hD4};

  neokeon_round_const_xor_pipe dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .out_rc(out_rc), .out_last(out_last), .busy(busy)
  );

  neokeon_round_const_xor_pipe #(.WORD_SEL(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt),
    .in_valid(in_valid), .in_ready(in_ready3), .in_state(in_state),
    .out_valid(out_valid3), .out_ready(out_ready), .out_state(out_state3),
    .out_rc(out_rc3), .out_last(out_last3), .busy(busy3)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic begin_block(input logic dec);
    @(negedge clk);
    start = 1'b1; decrypt = dec;
    @(negedge clk);
    start = 1'b0; decrypt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_state !== 128'h0) begin errors++; $display("FAIL rst_out_state: got %h expected 0", out_state); end
    checks++; if (out_rc !== 8'h00) begin errors++; $display("FAIL rst_out_rc: got %h expected 00", out_rc); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b expected 0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL idle_no_accept: got in_ready=%b out_valid=%b expected 0/0", in_ready, out_valid);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_encrypt();
    logic [127:0] exp_s, exp_s3;
    apply_reset();
    out_ready = 1'b1; in_state = '0;
    begin_block(1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      exp_s  = {24'h0, enc_rc[i], 96'h0};
      exp_s3 = {120'h0, enc_rc[i]};
      checks++; if (out_valid !== 1'b1 || out_rc !== enc_rc[i]) begin
        errors++; $display("FAIL enc_rc[%0d]: got valid=%b rc=%h expected 1/%h", i, out_valid, out_rc, enc_rc[i]);
      end
      checks++; if (out_state !== exp_s) begin
        errors++; $display("FAIL enc_state[%0d]: got %h expected %h", i, out_state, exp_s);
      end
      checks++; if (out_state3 !== exp_s3) begin
        errors++; $display("FAIL enc_state_w3[%0d]: got %h expected %h", i, out_state3, exp_s3);
      end
      checks++; if (out_last !== (i == 16)) begin
        errors++; $display("FAIL enc_last[%0d]: got %b expected %b", i, out_last, (i == 16));
      end
      checks++; if (busy !== (i != 16)) begin
        errors++; $display("FAIL enc_busy[%0d]: got %b expected %b", i, busy, (i != 16));
      end
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL enc_no_18th: got in_ready=%b expected 0", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL enc_drained: got out_valid=%b expected 0", out_valid); end
    in_valid = 1'b0;
  endtask

  task automatic test_decrypt();
    apply_reset();
    out_ready = 1'b1; in_state = '0;
    begin_block(1'b1);
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_rc !== enc_rc[16-i]) begin
        errors++; $display("FAIL dec_rc[%0d]: got valid=%b rc=%h expected 1/%h", i, out_valid, out_rc, enc_rc[16-i]);
      end
      checks++; if (out_last !== (i == 16)) begin
        errors++; $display("FAIL dec_last[%0d]: got %b expected %b", i, out_last, (i == 16));
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dec_idle: got busy=%b expected 0", busy); end
    in_valid = 1'b0;
  endtask

  task automatic test_all_ones();
    apply_reset();
    out_ready = 1'b1; in_state = '1;
    begin_block(1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_state !== 128'hFFFFFF7F_FFFFFFFF_FFFFFFFF_FFFFFFFF) begin
      errors++; $display("FAIL ones_w0: got %h expected FFFFFF7F_FF..FF", out_state);
    end
    checks++; if (out_state3 !== 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF7F) begin
      errors++; $display("FAIL ones_w3: got %h expected FF..FF_FFFFFF7F", out_state3);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready = 1'b0; in_state = '0;
    begin_block(1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    in_state = {4{32'hA5A5A5A5}};
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_valid !== 1'b1 || out_rc !== 8'h80 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_ctl[%0d]: got valid=%b rc=%h in_ready=%b expected 1/80/0", k, out_valid, out_rc, in_ready);
      end
      checks++; if (out_state !== {24'h0, 8'h80, 96'h0}) begin
        errors++; $display("FAIL bp_hold_state[%0d]: got %h expected 00000080_0..0", k, out_state);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_rc !== 8'h1B) begin
      errors++; $display("FAIL bp_second_rc: got valid=%b rc=%h expected 1/1B", out_valid, out_rc);
    end
    checks++; if (out_state !== 128'hA5A5A5BE_A5A5A5A5_A5A5A5A5_A5A5A5A5) begin
      errors++; $display("FAIL bp_second_state: got %h expected A5A5A5BE_A5..A5", out_state);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    out_ready = 1'b1; in_state = '0;
    begin_block(1'b0);
    in_valid = 1'b1;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_rc !== 8'hAB) begin
      errors++; $display("FAIL ar_sixth: got valid=%b rc=%h expected 1/AB", out_valid, out_rc);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_rc !== 8'h00) begin
      errors++; $display("FAIL ar_immediate: got valid=%b busy=%b rc=%h expected 0/0/00", out_valid, busy, out_rc);
    end
    #1 rst = 1'b0;
    begin_block(1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_rc !== 8'h80 || out_last !== 1'b0) begin
      errors++; $display("FAIL ar_restart: got valid=%b rc=%h last=%b expected 1/80/0", out_valid, out_rc, out_last);
    end
  endtask

  task automatic test_start_ignored();
    apply_reset();
    out_ready = 1'b1; in_state = '0;
    begin_block(1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start   = (i >= 1 && i <= 3);
      decrypt = start;
      @(negedge clk);
      checks++; if (out_rc !== enc_rc[i] || busy !== 1'b1) begin
        errors++; $display("FAIL start_ignored[%0d]: got rc=%h busy=%b expected %h/1", i, out_rc, busy, enc_rc[i]);
      end
    end
    start = 1'b0; decrypt = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    out_ready = 1'b1; in_state = '0;
    begin_block(1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      checks++; if (out_rc !== enc_rc[i]) begin
        errors++; $display("FAIL b2b_rc[%0d]: got %h expected %h", i, out_rc, enc_rc[i]);
      end
    end
    start = 1'b1; decrypt = 1'b1;
    @(negedge clk);
    start = 1'b0; decrypt = 1'b0;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_restart: got busy=%b valid=%b in_ready=%b expected 1/0/1", busy, out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_rc !== 8'hD4) begin
      errors++; $display("FAIL b2b_dec_first: got valid=%b rc=%h expected 1/D4", out_valid, out_rc);
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; start = 1'b0; decrypt = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; in_state = '0;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_all_ones();
    test_backpressure();
    test_async_reset();
    test_start_ignored();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
